// File: rtl/fraction_pkg.sv
// Shared definitions for the fraction reducer: default width and FSM state encoding.
package fraction_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_NUM = 2'd1,
    DIV_DEN = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sub_divider.sv
// Repeated-subtraction divider datapath: one subtraction of g from rem per step,
// counting the quotient in q. finish is high once rem < g.
module sub_divider
  import fraction_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] g,
  output logic [W-1:0] q,
  output logic [W-1:0] rem,
  output logic         finish
);

  assign finish = (rem < g);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
      q   <= '0;
    end else if (load) begin
      rem <= load_val;
      q   <= '0;
    end else if (step && !finish) begin
      rem <= rem - g;
      q   <= q + W'(1);
    end
  end

endmodule

// File: rtl/fraction_reducer.sv
// Reduces a num/den pair by a supplied GCD using one shared subtractive divider,
// first for the numerator, then for the denominator.
module fraction_reducer
  import fraction_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  input  logic [W-1:0] gcd,
  output logic         busy,
  output logic         out_valid,
  output logic [W-1:0] num_red,
  output logic [W-1:0] den_red,
  output logic         err,
  output logic         overrun
);

  state_t       state_q, state_d;
  logic [W-1:0] g, den_hold;
  logic [W-1:0] load_val, q, rem;
  logic         load, step, finish;

  assign busy    = (state_q != IDLE);
  assign overrun = in_valid && busy;

  sub_divider #(.W(W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .g        (g),
    .q        (q),
    .rem      (rem),
    .finish   (finish)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = num;
    step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = (gcd == '0) ? DONE : DIV_NUM;
        end
      end
      DIV_NUM: begin
        if (finish) begin
          load     = 1'b1;
          load_val = den_hold;
          state_d  = DIV_DEN;
        end else begin
          step = 1'b1;
        end
      end
      DIV_DEN: begin
        if (finish) state_d = DONE;
        else        step    = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // out_valid is registered off DONE, so it pulses on the edge leaving DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      g         <= '0;
      den_hold  <= '0;
      num_red   <= '0;
      den_red   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            g        <= gcd;
            den_hold <= den;
            if (gcd == '0) begin
              num_red <= num;
              den_red <= den;
              err     <= 1'b1;
            end
          end
        end
        DIV_NUM: begin
          if (finish) begin
            num_red <= q;
            err     <= (rem != '0);
          end
        end
        DIV_DEN: begin
          if (finish) begin
            den_red <= q;
            err     <= err | (rem != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
